update_scheduler: RTL and testbench
===================================

UPDATE_SCHEDULER -- requirements
Module: update_scheduler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DEPTH, 4, request FIFO entries; power of two, range 2..16.
- TIMEOUT, 65535, maximum cycles to wait for cmd_done before flagging an error.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state is updated on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- req_valid, in, 2, per-requester request valid (bit 0 = game logic, bit 1 = background).
- req_x, in, 2x4, per-requester x tile coordinate.
- req_y, in, 2x4, per-requester y tile coordinate.
- req_obj, in, 2x3, per-requester object code.
- req_ready, out, 2, per-requester grant; a request transfers when valid and ready are both high on a clock edge.
- cmd_done, in, 1, one-cycle completion pulse from the pixel updater.
- init_cycle, out, 1, display-initialisation command to the pixel updater.
- en_update, out, 1, pixel-update command to the pixel updater.
- x, out, 4, coordinate driven to the pixel updater.
- y, out, 4, coordinate driven to the pixel updater.
- obj_code, out, 3, object code driven to the pixel updater.
- init_done, out, 1, high once display initialisation has completed.
- busy, out, 1, high while a command is outstanding.
- fifo_count, out, $clog2(DEPTH)+1, number of queued requests.
- timeout_err, out, 1, sticky flag set when a cmd_done wait exceeds TIMEOUT.

Function
REQ-003 The FSM SHALL have the states INIT, INIT_WAIT, IDLE, UPD and UPD_WAIT.
REQ-004 Transitions SHALL be as follows:
- INIT goes to INIT_WAIT after one cycle.
- INIT_WAIT goes to IDLE on cmd_done.
- IDLE goes to UPD when the FIFO is non-empty.
- UPD goes to UPD_WAIT after one cycle.
- UPD_WAIT goes to IDLE on cmd_done.
REQ-005 init_cycle SHALL be high in INIT and INIT_WAIT, and SHALL be low from the first cycle after cmd_done is sampled.
REQ-006 en_update SHALL be high in UPD and UPD_WAIT, and SHALL be low from the first cycle after cmd_done is sampled.
REQ-007 In UPD the FIFO head SHALL be popped into registers that drive x, y and obj_code, and these outputs SHALL be held stable until the next pop.
REQ-008 The latency from a request transfer into an empty FIFO in IDLE to en_update high SHALL be 2 cycles.
REQ-009 cmd_done received in INIT, IDLE or UPD SHALL be ignored.
REQ-010 init_done SHALL be set on the cmd_done that ends INIT_WAIT and SHALL remain set until reset.
REQ-011 busy SHALL equal init_cycle OR en_update.
REQ-012 Requests SHALL be accepted in every state, including during initialisation; they are queued and issued only once init_done is high.
REQ-013 Arbitration SHALL grant at most one requester per cycle, round-robin:
- the last-granted requester has lowest priority;
- the pointer starts at requester 0 after reset;
- a lone valid requester is granted immediately.
REQ-014 req_ready SHALL be asserted only for the granted requester and only when the FIFO is not full, or when a pop occurs in the same cycle.
REQ-015 A simultaneous push and pop SHALL leave fifo_count unchanged. A push into a full FIFO cannot occur because of REQ-014.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH.
REQ-017 fifo_count SHALL saturate at neither end, by construction.
REQ-018 The wait counter SHALL clear on entry to INIT_WAIT or UPD_WAIT and increment each wait cycle. At TIMEOUT the FSM SHALL:
- set timeout_err;
- drop the active command;
- go to IDLE (from UPD_WAIT) or retry INIT (from INIT_WAIT).
REQ-019 The arbiter SHALL have no combinational path from cmd_done to req_ready.

Reset
REQ-020 While rst is high, the following SHALL be forced asynchronously:
- FSM state to INIT;
- FIFO empty, fifo_count = 0, round-robin pointer = 0;
- wait counter = 0;
- init_cycle = 0, en_update = 0, x = 0, y = 0, obj_code = 0;
- init_done = 0, timeout_err = 0, req_ready = 0.
REQ-021 On release of rst, init_cycle SHALL rise on the first rising clk edge.
REQ-022 Reset asserted mid-command SHALL abort the command and discard all queued requests.

Structure
REQ-023 A shared package SHALL hold the state enum, the request struct {x[3:0], y[3:0], obj[2:0]} and the TIMEOUT default.
REQ-024 The FIFO SHALL be a sub-module named req_fifo (parameter DEPTH; push/pop/full/empty/count); arbiter, FSM and wait counter stay in update_scheduler.

Verification
REQ-025 Reset/init: release rst and pulse cmd_done 10 cycles later. Required: init_cycle high for cycles 1..11, low at cycle 12; init_done = 1.
REQ-026 Single update: after init, requester 0 sends x=3, y=5, obj=2. Required: en_update high 2 cycles later with x=3, y=5, obj_code=2; low the cycle after cmd_done.
REQ-027 Round-robin: both requesters are continuously valid with distinct payloads for 4 transfers. Required: grant order 0,1,0,1 and issue order matching.
REQ-028 FIFO full with DEPTH=4: hold cmd_done low and push 5 requests during UPD_WAIT. Required: fifo_count reaches 4 (one request is popped into the active command); req_ready low; pushes resume after the next cmd_done; no request is lost.
REQ-029 Timeout with TIMEOUT=20: never pulse cmd_done in UPD_WAIT. Required: timeout_err = 1 after 20 wait cycles, en_update = 0, FSM in IDLE; the next queued request issues.
REQ-030 Mid-operation reset: assert rst during UPD_WAIT with 3 requests queued. Required: all outputs return to their REQ-020 values immediately and fifo_count = 0.

Source files
------------

// File: rtl/update_scheduler_pkg.sv
// Shared types for the pixel-update scheduler: FSM states, request payload
// and the round-robin grant helper.
package update_scheduler_pkg;

  localparam int TIMEOUT_DEFAULT = 65535;
  localparam int NUM_REQ         = 2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_UPD,
    ST_UPD_WAIT
  } state_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] obj;
  } req_t;

  // One-hot grant: the requester named by prio wins if valid, otherwise the other one.
  function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic prio);
    logic [1:0] g;
    g = 2'b00;
    if (valid[prio]) begin
      g[prio] = 1'b1;
    end else if (valid[~prio]) begin
      g[~prio] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/update_scheduler_req_fifo.sv
// Request FIFO: DEPTH entries (power of two), pointers wrap naturally,
// simultaneous push and pop keeps the occupancy constant.
module req_fifo
  import update_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  req_t                   wdata,
  output req_t                   rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  req_t                mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [AW:0]         count_q;
  logic                do_push;
  logic                do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Payload storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/update_scheduler.sv
// Pixel-update scheduler: arbitrates two requesters into a FIFO, runs the
// display init handshake, then issues queued updates one at a time.
//
// state        | meaning
// ST_INIT      | one cycle; launches (or relaunches) the display init command
// ST_INIT_WAIT | init_cycle high, waiting for cmd_done or timeout
// ST_IDLE      | no command outstanding; leaves as soon as the FIFO has data
// ST_UPD       | pops the FIFO head into the x/y/obj_code registers
// ST_UPD_WAIT  | en_update high, waiting for cmd_done or timeout
module update_scheduler
  import update_scheduler_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  input  logic [7:0]             req_x,
  input  logic [7:0]             req_y,
  input  logic [5:0]             req_obj,
  output logic [1:0]             req_ready,
  input  logic                   cmd_done,
  output logic                   init_cycle,
  output logic                   en_update,
  output logic [3:0]             x,
  output logic [3:0]             y,
  output logic [2:0]             obj_code,
  output logic                   init_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   timeout_err
);

  localparam int              WW        = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT - 1);

  state_t        state_q;
  logic [WW-1:0] wait_q;
  logic          init_cycle_q;
  logic          en_update_q;
  logic          init_done_q;
  logic          timeout_err_q;
  logic [3:0]    x_q;
  logic [3:0]    y_q;
  logic [2:0]    obj_q;

  logic          rr_q;
  logic          rr_d;
  logic [1:0]    grant;
  logic          can_push;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  req_t          push_req;
  req_t          head_req;

  // The pop depends only on registered state, so cmd_done never reaches req_ready.
  assign pop = (state_q == ST_UPD);

  // Round-robin arbiter and push-side payload mux.
  always_comb begin
    grant        = rr_grant(req_valid, rr_q);
    can_push     = !fifo_full || pop;
    req_ready    = (rst || !can_push) ? 2'b00 : grant;
    push         = |req_ready;
    push_req.x   = grant[1] ? req_x[7:4]   : req_x[3:0];
    push_req.y   = grant[1] ? req_y[7:4]   : req_y[3:0];
    push_req.obj = grant[1] ? req_obj[5:3] : req_obj[2:0];
    // rr_q names the requester with top priority; the one just granted drops to last.
    rr_d         = push ? grant[0] : rr_q;
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_req),
    .rdata (head_req),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sequencing FSM with wait counter; command outputs are registered and follow the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_INIT;
      wait_q        <= '0;
      init_cycle_q  <= 1'b0;
      en_update_q   <= 1'b0;
      init_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      obj_q         <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          state_q      <= ST_INIT_WAIT;
          init_cycle_q <= 1'b1;
          wait_q       <= '0;
        end
        ST_INIT_WAIT: begin
          if (cmd_done) begin
            state_q      <= ST_IDLE;
            init_cycle_q <= 1'b0;
            init_done_q  <= 1'b1;
          end else if (wait_q == WAIT_LAST) begin
            state_q       <= ST_INIT;
            init_cycle_q  <= 1'b0;
            timeout_err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q <= ST_UPD;
          end
        end
        ST_UPD: begin
          state_q     <= ST_UPD_WAIT;
          en_update_q <= 1'b1;
          wait_q      <= '0;
          x_q         <= head_req.x;
          y_q         <= head_req.y;
          obj_q       <= head_req.obj;
        end
        ST_UPD_WAIT: begin
          if (cmd_done) begin
            state_q     <= ST_IDLE;
            en_update_q <= 1'b0;
          end else if (wait_q == WAIT_LAST) begin
            state_q       <= ST_IDLE;
            en_update_q   <= 1'b0;
            timeout_err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  assign init_cycle  = init_cycle_q;
  assign en_update   = en_update_q;
  assign init_done   = init_done_q;
  assign timeout_err = timeout_err_q;
  assign busy        = init_cycle_q | en_update_q;
  assign x           = x_q;
  assign y           = y_q;
  assign obj_code    = obj_q;

endmodule

// File: tb/tb_update_scheduler.sv
// Scoreboard bench for update_scheduler: transfers push the expected payload,
// a monitor pops and compares on every rising en_update.
module tb_update_scheduler;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [7:0] req_x;
  logic [7:0] req_y;
  logic [5:0] req_obj;
  logic [1:0] req_ready;
  logic       cmd_done;
  logic       auto_pulse;
  logic       man_pulse;
  logic       auto_done;
  logic       init_cycle;
  logic       en_update;
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] obj_code;
  logic       init_done;
  logic       busy;
  logic [2:0] fifo_count;
  logic       timeout_err;

  logic [10:0] exp_q[$];
  int          grant_q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;

  assign cmd_done = auto_pulse | man_pulse;

  always #5 clk = ~clk;

  update_scheduler #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_obj     (req_obj),
    .req_ready   (req_ready),
    .cmd_done    (cmd_done),
    .init_cycle  (init_cycle),
    .en_update   (en_update),
    .x           (x),
    .y           (y),
    .obj_code    (obj_code),
    .init_done   (init_done),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .timeout_err (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    total_cnt++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one request; returns #1 after the edge on which it transferred.
  task automatic send(input int r, input logic [3:0] xx, input logic [3:0] yy, input logic [2:0] oo);
    bit done;
    done = 1'b0;
    req_x[4*r +: 4]   = xx;
    req_y[4*r +: 4]   = yy;
    req_obj[3*r +: 3] = oo;
    req_valid[r]      = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        @(posedge clk);
        #1;
        exp_q.push_back({xx, yy, oo});
        grant_q.push_back(r);
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    req_valid[r] = 1'b0;
    if (!done) expire("send");
  endtask

  task automatic wait_en_high();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      if (en_update) ok = 1'b1;
    end
    if (!ok) expire("wait_en_high");
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (!busy && fifo_count == 0 && exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) expire("wait_drain");
  endtask

  // Responder: completes each update three cycles after en_update rises.
  initial begin
    int en_cnt;
    en_cnt     = 0;
    auto_pulse = 1'b0;
    forever begin
      tick();
      auto_pulse = 1'b0;
      if (auto_done && en_update) begin
        en_cnt++;
        if (en_cnt == 3) begin
          auto_pulse = 1'b1;
          en_cnt     = 0;
        end
      end else begin
        en_cnt = 0;
      end
    end
  end

  // Monitor: every new update command must carry the oldest expected payload.
  initial begin
    logic        en_prev;
    logic [10:0] e;
    en_prev = 1'b0;
    forever begin
      tick();
      if (en_update && !en_prev) begin
        if (exp_q.size() == 0) begin
          expire("issue_unexpected");
        end else begin
          e = exp_q.pop_front();
          check("issue_payload", {x, y, obj_code}, e);
        end
      end
      en_prev = en_update;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp[4];
    rr_exp = '{0, 1, 0, 1};

    rst       = 1'b1;
    req_valid = 2'b11;
    req_x     = '0;
    req_y     = '0;
    req_obj   = '0;
    man_pulse = 1'b0;
    auto_done = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_init_cycle", init_cycle, 0);
    check("rst_en_update", en_update, 0);
    check("rst_init_done", init_done, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_req_ready", req_ready, 0);
    req_valid = 2'b00;

    // Init handshake: init_cycle high after edges 1..11, cmd_done sampled on edge 12
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      check($sformatf("init_cycle_c%0d", c), init_cycle, (c <= 11) ? 1 : 0);
      if (c == 11) man_pulse = 1'b1;
      if (c == 12) man_pulse = 1'b0;
    end
    check("init_done_set", init_done, 1);
    check("init_busy_low", busy, 0);

    // Stray cmd_done in IDLE is ignored
    man_pulse = 1'b1;
    tick();
    man_pulse = 1'b0;
    tick();
    check("idle_done_en", en_update, 0);
    check("idle_done_busy", busy, 0);
    check("idle_init_done", init_done, 1);

    // Round-robin with both requesters continuously valid
    auto_done = 1'b1;
    grant_q.delete();
    fork
      begin
        send(0, 4'd1, 4'd2, 3'd3);
        send(0, 4'd4, 4'd5, 3'd6);
      end
      begin
        send(1, 4'd7, 4'd8, 3'd1);
        send(1, 4'd9, 4'd10, 3'd5);
      end
    join
    check("rr_grant_count", grant_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_q.size()) check($sformatf("rr_grant_%0d", i), grant_q[i], rr_exp[i]);
    end
    wait_drain();

    // Single update: two-cycle latency, drop the cycle after cmd_done
    auto_done = 1'b0;
    send(0, 4'd3, 4'd5, 3'd2);
    check("single_en_t1", en_update, 0);
    tick();
    check("single_en_t1b", en_update, 0);
    tick();
    check("single_en_t2", en_update, 1);
    check("single_xyo", {x, y, obj_code}, {4'd3, 4'd5, 3'd2});
    check("single_busy", busy, 1);
    man_pulse = 1'b1;
    tick();
    man_pulse = 1'b0;
    check("single_en_off", en_update, 0);
    check("single_hold_x", x, 3);
    check("single_busy_off", busy, 0);

    // FIFO full: one active command plus four queued, fifth stalls
    send(0, 4'd1, 4'd1, 3'd1);
    wait_en_high();
    send(0, 4'd2, 4'd2, 3'd2);
    send(0, 4'd3, 4'd3, 3'd3);
    send(0, 4'd4, 4'd4, 3'd4);
    send(0, 4'd5, 4'd5, 3'd5);
    check("full_count", fifo_count, 4);
    req_x[3:0]   = 4'd6;
    req_y[3:0]   = 4'd6;
    req_obj[2:0] = 3'd6;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("full_ready_low", req_ready, 0);
      check("full_count_hold", fifo_count, 4);
      @(posedge clk);
      #1;
    end
    man_pulse = 1'b1;
    tick();
    man_pulse = 1'b0;
    send(0, 4'd6, 4'd6, 3'd6);
    check("full_push_pop_count", fifo_count, 4);
    auto_done = 1'b1;
    wait_drain();
    check("full_no_timeout", timeout_err, 0);

    // Timeout: 20 wait cycles without cmd_done, then next request issues
    auto_done = 1'b0;
    send(0, 4'd10, 4'd11, 3'd3);
    send(1, 4'd12, 4'd13, 3'd4);
    wait_en_high();
    repeat (19) tick();
    check("to_err_before", timeout_err, 0);
    check("to_en_before", en_update, 1);
    tick();
    check("to_err_set", timeout_err, 1);
    check("to_en_dropped", en_update, 0);
    check("to_busy_idle", busy, 0);
    tick();
    tick();
    check("to_next_issue", en_update, 1);
    auto_done = 1'b1;
    wait_drain();
    check("to_err_sticky", timeout_err, 1);

    // Mid-command reset with three requests queued
    auto_done = 1'b0;
    send(0, 4'd1, 4'd2, 3'd1);
    send(0, 4'd3, 4'd4, 3'd2);
    send(0, 4'd5, 4'd6, 3'd3);
    send(0, 4'd7, 4'd8, 3'd4);
    wait_en_high();
    check("mid_count", fifo_count, 3);
    req_valid = 2'b11;
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_en", en_update, 0);
    check("mid_init_cycle", init_cycle, 0);
    check("mid_xyo", {x, y, obj_code}, 0);
    check("mid_init_done", init_done, 0);
    check("mid_timeout_err", timeout_err, 0);
    check("mid_req_ready", req_ready, 0);
    check("mid_fifo_count", fifo_count, 0);
    check("mid_busy", busy, 0);
    req_valid = 2'b00;
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_init_cycle", init_cycle, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
